// File: rtl/wb_arbiter_2to1.sv
// wb_arbiter_2to1: two-master, one-slave Wishbone classic arbiter.
// Shares one slave between master 0 (instruction fetch) and master 1 (data).
// Ownership is held for a whole Wishbone cycle (cyc high). Simultaneous
// requests from IDLE are resolved round-robin against the previous owner.
// Optional watchdog (compile with `define WB_ARBITER_TIMEOUT_EN) errors a
// cycle whose strobe has gone TIMEOUT_CYCLES clocks without a termination.
module wb_arbiter_2to1 #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // master 0
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic        m0_rty_o,
  // master 1
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        m1_rty_o,
  // slave
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  input  logic        s_rty_i,
  // owner indication
  output logic [1:0]  grant_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        last_q, last_d;     // most recent owner: 0 = m0, 1 = m1
  logic [1:0]  grant_q, grant_d;   // one-hot copy of the state, drives the muxes
  logic        wd_err;             // watchdog firing this cycle
  logic        own_stb;            // owner's strobe before watchdog gating

  // Ownership decision: hold for the whole cycle, hand over directly if the
  // other master is waiting, round-robin on a tie from IDLE.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = last_q ? OWN0 : OWN1;
        end else if (m0_cyc_i) begin
          state_d = OWN0;
        end else if (m1_cyc_i) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        if (!m0_cyc_i) begin
          last_d  = 1'b0;
          state_d = m1_cyc_i ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (!m1_cyc_i) begin
          last_d  = 1'b1;
          state_d = m0_cyc_i ? OWN0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    grant_d = {state_d == OWN1, state_d == OWN0};
  end

  // Arbiter state and registered grant; reset favours m0 on the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      grant_q <= 2'b00;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
    end
  end

  assign grant_o = grant_q;

  // Route the owner's request to the slave; everything is zero while idle.
  always_comb begin
    s_cyc_o = 1'b0;
    own_stb = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_sel_o = '0;
    s_dat_o = '0;
    if (grant_q[0]) begin
      s_cyc_o = m0_cyc_i;
      own_stb = m0_stb_i;
      s_we_o  = m0_we_i;
      s_adr_o = m0_adr_i;
      s_sel_o = m0_sel_i;
      s_dat_o = m0_dat_i;
    end else if (grant_q[1]) begin
      s_cyc_o = m1_cyc_i;
      own_stb = m1_stb_i;
      s_we_o  = m1_we_i;
      s_adr_o = m1_adr_i;
      s_sel_o = m1_sel_i;
      s_dat_o = m1_dat_i;
    end
  end

  // A watchdog error replaces the slave's strobe so the slave never sees a
  // transfer the master has already been told failed.
  assign s_stb_o = own_stb & ~wd_err;

  // Terminations and read data go back only to the current owner.
  always_comb begin
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_rty_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_rty_o = 1'b0;
    if (grant_q[0]) begin
      m0_dat_o = s_dat_i;
      m0_ack_o = s_ack_i & ~wd_err;
      m0_err_o = s_err_i | wd_err;
      m0_rty_o = s_rty_i & ~wd_err;
    end else if (grant_q[1]) begin
      m1_dat_o = s_dat_i;
      m1_ack_o = s_ack_i & ~wd_err;
      m1_err_o = s_err_i | wd_err;
      m1_rty_o = s_rty_i & ~wd_err;
    end
  end

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("wb_arbiter_2to1: TIMEOUT_CYCLES must be at least 2");
  end

`ifdef WB_ARBITER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic             to_q, to_d;
  logic             slv_term;

  assign slv_term = s_ack_i | s_err_i | s_rty_i;

  // Count consecutive unanswered strobes of the current owner; fire once on
  // reaching the limit and start over, so a master that keeps strobing gets
  // a fresh error every TIMEOUT_CYCLES + 1 clocks.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    to_d     = 1'b0;
    if ((state_q == IDLE) || (state_d != state_q)) begin
      wd_cnt_d = '0;
    end else if (slv_term) begin
      wd_cnt_d = '0;
    end else if (s_stb_o) begin
      if (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        wd_cnt_d = '0;
        to_d     = 1'b1;
      end else begin
        wd_cnt_d = wd_cnt_q + CNT_W'(1);
      end
    end
  end

  // Watchdog counter and its one-cycle error pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_cnt_q <= '0;
      to_q     <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      to_q     <= to_d;
    end
  end

  assign wd_err = to_q;
`else
  assign wd_err = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter_2to1.sv
// Self-checking bench for wb_arbiter_2to1: directed scenarios with literal
// expectations, then randomized traffic from two masters, with every cycle
// compared against an owner-level model of the arbiter.
module tb_wb_arbiter_2to1;
  localparam int T_TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mcyc, mstb, mwe;
  logic [31:0] madr [2];
  logic [3:0]  msel [2];
  logic [31:0] mdat [2];
  logic [31:0] mdat_o [2];
  logic [1:0]  mack, merr, mrty;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_dat_w, s_dat_r;
  logic [3:0]  s_sel;
  logic        s_ack, s_err, s_rty;
  logic [1:0]  grant;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  wb_arbiter_2to1 #(.TIMEOUT_CYCLES(T_TO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_cyc_i(mcyc[0]), .m0_stb_i(mstb[0]), .m0_we_i(mwe[0]),
    .m0_adr_i(madr[0]), .m0_sel_i(msel[0]), .m0_dat_i(mdat[0]),
    .m0_dat_o(mdat_o[0]), .m0_ack_o(mack[0]), .m0_err_o(merr[0]), .m0_rty_o(mrty[0]),
    .m1_cyc_i(mcyc[1]), .m1_stb_i(mstb[1]), .m1_we_i(mwe[1]),
    .m1_adr_i(madr[1]), .m1_sel_i(msel[1]), .m1_dat_i(mdat[1]),
    .m1_dat_o(mdat_o[1]), .m1_ack_o(mack[1]), .m1_err_o(merr[1]), .m1_rty_o(mrty[1]),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr),
    .s_sel_o(s_sel), .s_dat_o(s_dat_w), .s_dat_i(s_dat_r),
    .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
    .grant_o(grant)
  );

  // Slave: registered-ack RAM. adr[13] = no response, adr[12] = error,
  // adr[14] = retry, otherwise 256-word RAM indexed by adr[9:2].
  logic [31:0] mem [0:255];
  logic        pl_we = 1'b0;
  logic [7:0]  pl_idx = '0;
  logic [31:0] pl_val = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ack <= 1'b0; s_err <= 1'b0; s_rty <= 1'b0; s_dat_r <= '0;
    end else begin
      if (pl_we) mem[pl_idx] <= pl_val;
      s_ack <= 1'b0; s_err <= 1'b0; s_rty <= 1'b0;
      if (s_cyc && s_stb && !(s_ack || s_err || s_rty) && !s_adr[13]) begin
        if (s_adr[12]) s_err <= 1'b1;
        else if (s_adr[14]) s_rty <= 1'b1;
        else begin
          s_ack <= 1'b1;
          s_dat_r <= mem[s_adr[9:2]];
          if (s_we)
            for (int b = 0; b < 4; b++)
              if (s_sel[b]) mem[s_adr[9:2]][8*b +: 8] <= s_dat_w[8*b +: 8];
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model: who owns the bus, who owned it last, and how long the
  // owner's strobe has gone unanswered. Checked every falling edge.
  int mo_own = -1;
  int mo_last = 1;
  int mo_cnt = 0;
  bit mo_to = 1'b0;

  always @(negedge clk) begin : cmp
    int o, no, nl, nc;
    bit nt, term;
    logic e_cyc, e_stb, e_we;
    logic [31:0] e_adr, e_wd;
    logic [3:0] e_sel;
    logic [1:0] e_gnt, e_ack, e_err, e_rty;
    logic [31:0] e_rd [2];
    if (!rst_n) begin
      mo_own = -1; mo_last = 1; mo_cnt = 0; mo_to = 1'b0;
    end
    o = mo_own;
    e_cyc = 0; e_stb = 0; e_we = 0; e_adr = '0; e_wd = '0; e_sel = '0;
    e_gnt = '0; e_ack = '0; e_err = '0; e_rty = '0; e_rd[0] = '0; e_rd[1] = '0;
    if (o >= 0) begin
      e_cyc = mcyc[o]; e_stb = mstb[o] & ~mo_to; e_we = mwe[o];
      e_adr = madr[o]; e_sel = msel[o]; e_wd = mdat[o];
      e_gnt[o] = 1'b1;
      e_ack[o] = s_ack & ~mo_to;
      e_err[o] = s_err | mo_to;
      e_rty[o] = s_rty & ~mo_to;
      e_rd[o] = s_dat_r;
    end
    chk("outputs",
        {s_cyc, s_stb, s_we, s_adr, s_sel, s_dat_w, grant, mack, merr, mrty, mdat_o[0], mdat_o[1]},
        {e_cyc, e_stb, e_we, e_adr, e_sel, e_wd, e_gnt, e_ack, e_err, e_rty, e_rd[0], e_rd[1]});
    if (rst_n) begin
      nl = mo_last;
      if (o < 0) begin
        if (mcyc[0] && mcyc[1]) no = 1 - mo_last;
        else if (mcyc[0]) no = 0;
        else if (mcyc[1]) no = 1;
        else no = -1;
      end else if (mcyc[o]) begin
        no = o;
      end else begin
        nl = o;
        no = mcyc[1-o] ? 1 - o : -1;
      end
      nc = 0; nt = 1'b0;
`ifdef WB_ARBITER_TIMEOUT_EN
      term = s_ack | s_err | s_rty;
      if (o >= 0 && no == o && !term && mstb[o] && !mo_to) begin
        if (mo_cnt + 1 == T_TO) nt = 1'b1;
        else nc = mo_cnt + 1;
      end else if (o >= 0 && no == o && !term) begin
        nc = mo_cnt;
      end
`else
      term = 1'b0;
`endif
      mo_own = no; mo_last = nl; mo_cnt = nc; mo_to = nt;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic setm(input int m, input bit c, input bit s, input bit w,
                      input logic [31:0] a, input logic [3:0] sel, input logic [31:0] d);
    mcyc[m] = c; mstb[m] = s; mwe[m] = w; madr[m] = a; msel[m] = sel; mdat[m] = d;
  endtask

  task automatic idle_m(input int m);
    setm(m, 0, 0, 0, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] val);
    pl_we = 1'b1; pl_idx = idx; pl_val = val;
    tick();
    pl_we = 1'b0;
  endtask

  task automatic do_reset();
    tick(); rst_n = 1'b0;
    tick(); tick(); rst_n = 1'b1;
  endtask

  task automatic new_beat(input int m);
    int r;
    r = $urandom_range(0, 9);
    mstb[m] = 1'b1;
    mwe[m] = 1'($urandom_range(0, 1));
    msel[m] = 4'($urandom);
    mdat[m] = $urandom;
    madr[m] = {22'h0, 8'($urandom), 2'b00};
    if (r == 8) madr[m][12] = 1'b1;
    if (r == 9) madr[m][14] = 1'b1;
  endtask

  initial begin : watchdog_tb
    #300000;
    $display("FAIL global_timeout: simulation did not finish, got time %0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    int acks, gbad, got, errs, stb_at;
    bit a;
    bit [1:0] term;
    idle_m(0); idle_m(1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_grant", grant, 2'b00);
    chk("reset_slave", {s_cyc, s_stb, mack, merr}, 0);
    preload(8'h40, 32'hDEADBEEF);
    preload(8'h20, 32'h11223344);

    // m0 read from IDLE
    setm(0, 1, 1, 0, 32'h100, 4'hF, 0);
    @(negedge clk); chk("rd_stb_N", s_stb, 0);
    tick(); @(negedge clk);
    chk("rd_stb_N1", s_stb, 1); chk("rd_gnt_N1", grant, 2'b01); chk("rd_ack_N1", mack, 2'b00);
    tick(); @(negedge clk);
    chk("rd_ack_N2", mack, 2'b01); chk("rd_dat_N2", mdat_o[0], 32'hDEADBEEF);
    tick(); idle_m(0);
    tick();

    // round-robin after reset
    do_reset();
    setm(0, 1, 1, 0, 32'h0, 4'hF, 0); setm(1, 1, 1, 0, 32'h4, 4'hF, 0);
    @(negedge clk); chk("rr_idle", grant, 2'b00);
    tick(); @(negedge clk); chk("rr_first_m0", grant, 2'b01);
    tick(); @(negedge clk); chk("rr_m0_ack", mack, 2'b01);
    tick(); idle_m(0); @(negedge clk); chk("rr_drop_cycle", {grant, mack}, 4'b0100);
    tick(); @(negedge clk); chk("rr_handover", grant, 2'b10);
    tick(); @(negedge clk); chk("rr_m1_ack", mack, 2'b10);
    tick(); idle_m(1);
    tick(); @(negedge clk); chk("rr_back_idle", grant, 2'b00);
    setm(0, 1, 1, 0, 32'h8, 4'hF, 0);
    tick(); tick(); @(negedge clk); chk("rr_m0_alone_ack", mack, 2'b01);
    tick(); idle_m(0);
    tick(); setm(0, 1, 1, 0, 32'hC, 4'hF, 0); setm(1, 1, 1, 0, 32'h10, 4'hF, 0);
    tick(); @(negedge clk); chk("rr_second_tie_m1", grant, 2'b10);
    tick(); @(negedge clk); chk("rr_second_m1_ack", mack, 2'b10);
    tick(); idle_m(1);
    tick(); @(negedge clk); chk("rr_direct_to_m0", grant, 2'b01);
    tick(); @(negedge clk); chk("rr_m0_late_ack", mack, 2'b01);
    tick(); idle_m(0);
    tick();

    // byte write by m1 while m0 waits, then m0 reads it back
    setm(1, 1, 1, 1, 32'h80, 4'b0010, 32'h0000AB00);
    tick(); setm(0, 1, 1, 0, 32'h80, 4'hF, 0);
    @(negedge clk); chk("bw_gnt_m1", grant, 2'b10); chk("bw_m0_wait0", mack[0], 0);
    tick(); @(negedge clk); chk("bw_m1_ack", mack, 2'b10);
    tick(); idle_m(1); @(negedge clk); chk("bw_m0_wait1", {grant, mack}, 4'b1000);
    tick(); @(negedge clk); chk("bw_m0_owns", {grant, mack}, 4'b0100);
    tick(); @(negedge clk);
    chk("bw_m0_ack", mack, 2'b01); chk("bw_rdata", mdat_o[0], 32'h1122AB44);
    tick(); idle_m(0);
    tick();

    // burst of 4 reads by m0 while m1 waits
    setm(0, 1, 1, 0, 32'h0, 4'hF, 0);
    tick(); setm(1, 1, 1, 0, 32'h10, 4'hF, 0);
    acks = 0; gbad = 0;
    for (int c = 0; c < 40 && acks < 4; c++) begin
      @(negedge clk);
      if (grant !== 2'b01) gbad++;
      a = mack[0];
      tick();
      if (a) begin
        acks++;
        if (acks < 4) madr[0] = 32'(acks * 4);
        else idle_m(0);
      end
    end
    chk("burst_acks", acks, 4); chk("burst_gnt_held", gbad, 0);
    @(negedge clk); chk("burst_drop_cycle", grant, 2'b01);
    tick(); @(negedge clk); chk("burst_handover", grant, 2'b10);
    tick(); @(negedge clk); chk("burst_m1_ack", mack, 2'b10);
    tick(); idle_m(1);
    tick();

    // stalled strobe to an unmapped address
    setm(0, 1, 1, 0, 32'h2000, 4'hF, 0);
    got = -1; errs = 0; gbad = 0; stb_at = -1;
    for (int k = 0; k < 21; k++) begin
      @(negedge clk);
      if (merr[0]) begin
        errs++;
        if (got < 0) begin got = k; stb_at = int'(s_stb); end
      end
      if (k >= 1 && grant !== 2'b01) gbad++;
      tick();
    end
`ifdef WB_ARBITER_TIMEOUT_EN
    chk("wd_err_cycle", got, 17); chk("wd_stb_gated", stb_at, 0); chk("wd_err_pulses", errs, 1);
`else
    chk("wd_no_err", errs, 0);
`endif
    chk("wd_grant_held", gbad, 0);
    idle_m(0);
    tick(); tick();

    // reset while m1 owns the bus and is being acked
    setm(1, 1, 1, 0, 32'h4, 4'hF, 0);
    tick(); tick();
    chk("rst_pre_state", {grant, mack}, 4'b1010);
    #2 rst_n = 1'b0;
    #1 chk("rst_async_zero", {s_cyc, grant, mack[1]}, 0);
    idle_m(1);
    tick(); tick(); rst_n = 1'b1;
    setm(0, 1, 1, 0, 32'h0, 4'hF, 0); setm(1, 1, 1, 0, 32'h4, 4'hF, 0);
    tick(); @(negedge clk); chk("rst_tie_m0", grant, 2'b01);
    tick(); tick(); idle_m(0); idle_m(1);
    tick(); tick();

    // randomized traffic from both masters
    term = 2'b00;
    for (int cy = 0; cy < 3000; cy++) begin
      for (int m = 0; m < 2; m++) begin
        if (mcyc[m]) begin
          if (mstb[m] && term[m]) begin
            if (($urandom_range(0, 2) == 0)) idle_m(m);
            else if ($urandom_range(0, 3) == 0) mstb[m] = 1'b0;
            else new_beat(m);
          end else if (!mstb[m] && $urandom_range(0, 1) == 1) begin
            new_beat(m);
          end
        end else if ($urandom_range(0, 2) == 0) begin
          mcyc[m] = 1'b1;
          if ($urandom_range(0, 3) == 0) mstb[m] = 1'b0;
          else new_beat(m);
        end
      end
      @(negedge clk);
      term = mack | merr | mrty;
      tick();
    end
    idle_m(0); idle_m(1);
    tick(); tick(); tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/wb_arbiter_2to1.md
# wb_arbiter_2to1

Two-master, one-slave Wishbone classic arbiter that shares the SoC block-RAM (or any single Wishbone slave) between the CPU instruction-fetch port (m0) and the data port (m1). It grants the bus per Wishbone cycle (`cyc` held), using round-robin priority on contention. It routes the owner's request to the slave and returns the slave's termination signals only to the owner. An optional watchdog terminates stalled cycles with an error.

## Interface
- `TIMEOUT_CYCLES`, 16, consecutive un-terminated strobe cycles before the watchdog errors the cycle (≥2; used only with the watchdog compiled in).

Ports:
- `clk_i`  in  1  clock; all state changes on rising edge.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `mX_cyc_i`, `mX_stb_i`, `mX_we_i`  in  1  master X (X = 0, 1) cycle, strobe and write enable.
- `mX_adr_i`  in  32  master X byte address.
- `mX_sel_i`  in  4  master X byte selects.
- `mX_dat_i`  in  32  master X write data.
- `mX_dat_o`  out  32  read data to master X.
- `mX_ack_o`, `mX_err_o`, `mX_rty_o`  out  1  cycle terminations to master X.
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1  slave cycle, strobe and write enable.
- `s_adr_o`  out  32  slave address.
- `s_sel_o`  out  4  slave byte selects.
- `s_dat_o`  out  32  slave write data.
- `s_dat_i`  in  32  slave read data.
- `s_ack_i`, `s_err_i`, `s_rty_i`  in  1  slave terminations.
- `grant_o`  out  2  one-hot owner (`01` = m0, `10` = m1, `00` = idle).

## Operation
- State register: IDLE, OWN0, OWN1. There is also a `last_q` register holding the most recent owner.
- **IDLE**
  - Only one `mX_cyc_i` high → OWNX.
  - Both high → grant the master that is not `last_q`.
  - Neither high → stay in IDLE.
- **OWNX**
  - Stay while `mX_cyc_i` is high. Owner keeps the bus across any number of strobes.
  - When `mX_cyc_i` is low: if the other master's `cyc` is high, go directly to OWN(other); otherwise go to IDLE.
  - `last_q` ← X on leaving.
- Slave outputs are a combinational mux of the owner's inputs.
- In IDLE, all slave outputs are 0.
- Owner's `dat_o`/`ack_o`/`err_o`/`rty_o` come combinationally from the slave. Non-owners see `ack`/`err`/`rty` = 0 and `dat_o` = 0.
- `s_stb_o` = owner's `stb` (gated as described under Configuration).
- Grant is registered. A request raised in IDLE reaches the slave on the next cycle. Masters hold `cyc`/`stb` until terminated, per Wishbone classic.
- Reset (asynchronous) forces IDLE, `last_q` = m1 (so m0 wins the first tie), and watchdog counter = 0. All outputs go to 0 immediately, including mid-transfer. An in-flight write may or may not have completed at the slave.

## Timing
- Idle-to-slave latency: request in cycle N → `s_stb_o` in N+1. With the registered-ack RAM, `mX_ack_o` arrives in N+2.
- While owned: slave sees a new strobe in the same cycle the master presents it (zero added latency).
- Handover: owner drops `cyc` in cycle K with the other master requesting → other master owns from K+1.
- A slave termination arriving during OWNX is never delivered to the other master, even at a handover edge.

## Configuration
- `WB_ARBITER_TIMEOUT_EN` defined:
  - Counter of width `$clog2(TIMEOUT_CYCLES+1)` increments each OWNX cycle with `s_stb_o`=1 and no `s_ack_i`/`s_err_i`/`s_rty_i`.
  - Counter clears on any termination, on state change, and after firing.
  - On reaching `TIMEOUT_CYCLES`, registered pulse `to_q` = 1 for one cycle. During that cycle, owner `err_o` = 1, `ack_o` = 0, and `s_stb_o` is forced to 0.
  - Owner keeps the grant until it drops `cyc`.
- Not defined: no counter and no `to_q`. `err_o` mirrors `s_err_i` only, and a stalled slave holds the bus indefinitely.

## Test plan
- **m0 read:** RAM[0x100] = 0xDEADBEEF; m0 reads 0x100 from IDLE in cycle N → `s_stb_o` = 1 at N+1; `m0_ack_o` = 1 with `m0_dat_o` = 0xDEADBEEF at N+2; `m1_ack_o` = 0 throughout.
- **Round-robin:** after reset both masters raise `cyc` together → m0 is granted first; m1 is granted the cycle after m0 drops `cyc`. Next simultaneous request → m1 is granted first.
- **Byte write while other waits:** m1 writes 0x0000AB00 with `sel` = 0010 to a word holding 0x11223344 while m0 requests → word reads 0x1122AB44; m0 sees no ack until it owns the bus.
- **Burst hold:** m0 issues 4 back-to-back reads under one `cyc` while m1 requests → `grant_o` stays 01 for all 4; m1 is granted the cycle after m0 drops `cyc`.
- **Watchdog:** with `WB_ARBITER_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 16, m0 strobes an unmapped address from N → `m0_err_o` is a one-cycle pulse at N+17 with `s_stb_o` = 0 in that cycle. Without the macro, there is no error and `grant_o` stays 01.
- **Reset mid-transfer:** `rst_ni` low during OWN1 → `s_cyc_o`, `grant_o` and `m1_ack_o` go to 0 before the next edge; after release, a simultaneous request grants m0.
